// File: rtl/reg_writeback_if.sv
// MEM->WB pipeline bus, register-file write port and decode bypass signals
// for the writeback stage. The master drives the MEM/decode side; the slave is the writeback stage.
interface reg_writeback_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_load_type;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic [31:0] mem_pc_plus8;
  logic [4:0]  id_addr_r1;
  logic [4:0]  id_addr_r2;
  logic [31:0] id_data_r1_raw;
  logic [31:0] id_data_r2_raw;
  logic        rf_we;
  logic [4:0]  rf_addr_w;
  logic [31:0] rf_data_w;
  logic [31:0] id_data_r1;
  logic [31:0] id_data_r2;
  logic        wb_valid;
  logic [31:0] retired_count;

  modport master (
    output mem_valid, mem_ready, mem_reg_write, mem_rd, mem_wb_sel,
           mem_load_type, mem_alu_result, mem_load_data, mem_pc_plus8,
           id_addr_r1, id_addr_r2, id_data_r1_raw, id_data_r2_raw,
    input  rf_we, rf_addr_w, rf_data_w, id_data_r1, id_data_r2,
           wb_valid, retired_count
  );

  modport slave (
    input  mem_valid, mem_ready, mem_reg_write, mem_rd, mem_wb_sel,
           mem_load_type, mem_alu_result, mem_load_data, mem_pc_plus8,
           id_addr_r1, id_addr_r2, id_data_r1_raw, id_data_r2_raw,
    output rf_we, rf_addr_w, rf_data_w, id_data_r1, id_data_r2,
           wb_valid, retired_count
  );
endinterface

// File: rtl/reg_writeback.sv
// MIPS writeback stage: MEM/WB register, result select with load extension,
// register-file write port, decode bypass and retired-instruction counter.
module reg_writeback (
  input  logic            clk,
  input  logic            rst,
  reg_writeback_if.slave  wb_if
);

  function automatic logic [31:0] load_extend(
    input logic [2:0]  load_type,
    input logic [1:0]  off,
    input logic [31:0] word
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    // Big-endian lanes: offset 0 is the most significant byte.
    case (off)
      2'd0:    byte_v = word[31:24];
      2'd1:    byte_v = word[23:16];
      2'd2:    byte_v = word[15:8];
      2'd3:    byte_v = word[7:0];
      default: byte_v = word[7:0];
    endcase
    if (off[1]) begin
      half_v = word[15:0];
    end else begin
      half_v = word[31:16];
    end
    case (load_type)
      3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  res_v = {{16{half_v[15]}}, half_v};
      3'b100:  res_v = {24'h00_0000, byte_v};
      3'b101:  res_v = {16'h0000, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

  logic        valid_next_s;
  logic [31:0] result_s;

  logic        wb_valid_q,     wb_valid_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic [4:0]  wb_rd_q,        wb_rd_d;
  logic [31:0] wb_result_q,    wb_result_d;
  logic [31:0] retired_count_q, retired_count_d;

  logic        rf_we_s;
  logic [31:0] id_data_r1_s;
  logic [31:0] id_data_r2_s;

  assign valid_next_s = wb_if.mem_valid & wb_if.mem_ready;

  // Result source selection ahead of the pipeline register.
  always_comb begin
    result_s = wb_if.mem_alu_result;
    case (wb_if.mem_wb_sel)
      2'b01:   result_s = load_extend(wb_if.mem_load_type,
                                      wb_if.mem_alu_result[1:0],
                                      wb_if.mem_load_data);
      2'b10:   result_s = wb_if.mem_pc_plus8;
      default: result_s = wb_if.mem_alu_result;
    endcase
  end

  // Next-state of the MEM/WB register: data holds on a bubble, valid clears.
  always_comb begin
    wb_valid_d     = valid_next_s;
    wb_reg_write_d = wb_reg_write_q;
    wb_rd_d        = wb_rd_q;
    wb_result_d    = wb_result_q;
    if (valid_next_s) begin
      wb_reg_write_d = wb_if.mem_reg_write;
      wb_rd_d        = wb_if.mem_rd;
      wb_result_d    = result_s;
    end else begin
      wb_reg_write_d = wb_reg_write_q;
      wb_rd_d        = wb_rd_q;
      wb_result_d    = wb_result_q;
    end
  end

  // Retirement counter next-state; wraps silently.
  always_comb begin
    if (wb_valid_q) begin
      retired_count_d = retired_count_q + 32'd1;
    end else begin
      retired_count_d = retired_count_q;
    end
  end

  // MEM/WB pipeline register and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_rd_q         <= 5'd0;
      wb_result_q     <= 32'h0000_0000;
      retired_count_q <= 32'h0000_0000;
    end else begin
      wb_valid_q      <= wb_valid_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_rd_q         <= wb_rd_d;
      wb_result_q     <= wb_result_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign rf_we_s = wb_valid_q & wb_reg_write_q & (wb_rd_q != 5'd0);

  // Decode bypass: the write in flight this cycle is not yet visible in the file.
  always_comb begin
    id_data_r1_s = wb_if.id_data_r1_raw;
    id_data_r2_s = wb_if.id_data_r2_raw;
    if (rf_we_s && (wb_if.id_addr_r1 == wb_rd_q) && (wb_if.id_addr_r1 != 5'd0)) begin
      id_data_r1_s = wb_result_q;
    end else begin
      id_data_r1_s = wb_if.id_data_r1_raw;
    end
    if (rf_we_s && (wb_if.id_addr_r2 == wb_rd_q) && (wb_if.id_addr_r2 != 5'd0)) begin
      id_data_r2_s = wb_result_q;
    end else begin
      id_data_r2_s = wb_if.id_data_r2_raw;
    end
  end

  assign wb_if.rf_we         = rf_we_s;
  assign wb_if.rf_addr_w     = wb_rd_q;
  assign wb_if.rf_data_w     = wb_result_q;
  assign wb_if.id_data_r1    = id_data_r1_s;
  assign wb_if.id_data_r2    = id_data_r2_s;
  assign wb_if.wb_valid      = wb_valid_q;
  assign wb_if.retired_count = retired_count_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus randomized
// traffic checked against a behavioural model of the writeback stage.
module tb_reg_writeback;

  logic clk;
  logic rst;
  reg_writeback_if bus ();

  reg_writeback dut (
    .clk   (clk),
    .rst   (rst),
    .wb_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model of what WB should hold
  logic        m_valid;
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_res;
  logic [31:0] m_cnt;

  function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    int          bsh;
    int          hsh;
    bsh = 8 * (3 - int'(off));
    hsh = off[1] ? 0 : 16;
    b = 8'(d >> bsh);
    h = 16'(d >> hsh);
    if (lt == 3'b000) return 32'($signed(b));
    if (lt == 3'b001) return 32'($signed(h));
    if (lt == 3'b100) return 32'(b);
    if (lt == 3'b101) return 32'(h);
    return d;
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] sel, input logic [2:0] lt,
                                             input logic [31:0] alu, input logic [31:0] ld,
                                             input logic [31:0] pc);
    if (sel == 2'b01) return ref_load(lt, alu[1:0], ld);
    if (sel == 2'b10) return pc;
    return alu;
  endfunction

  function automatic logic m_we();
    return m_valid && m_rw && (m_rd != 5'd0);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_res = 32'h0; m_cnt = 32'h0;
  endtask

  // Present one MEM instruction, take one rising edge, advance the model.
  task automatic clock_in(input logic v, input logic r, input logic rw, input logic [4:0] rd,
                          input logic [1:0] sel, input logic [2:0] lt, input logic [31:0] alu,
                          input logic [31:0] ld, input logic [31:0] pc);
    bus.mem_valid = v; bus.mem_ready = r; bus.mem_reg_write = rw; bus.mem_rd = rd;
    bus.mem_wb_sel = sel; bus.mem_load_type = lt; bus.mem_alu_result = alu;
    bus.mem_load_data = ld; bus.mem_pc_plus8 = pc;
    @(posedge clk);
    if (m_valid) m_cnt = m_cnt + 32'd1;
    m_valid = v && r;
    if (v && r) begin
      m_rw = rw; m_rd = rd; m_res = ref_result(sel, lt, alu, ld, pc);
    end
    #1;
  endtask

  task automatic idle();
    clock_in(1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%0b exp=0", bus.wb_valid); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%0b exp=0", bus.rf_we); end
    checks++; if (bus.rf_addr_w !== 5'd0) begin errors++; $display("FAIL reset_rf_addr_w got=%0d exp=0", bus.rf_addr_w); end
    checks++; if (bus.rf_data_w !== 32'h0) begin errors++; $display("FAIL reset_rf_data_w got=%h exp=0", bus.rf_data_w); end
    checks++; if (bus.retired_count !== 32'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", bus.retired_count); end
    bus.id_addr_r1 = 5'd3; bus.id_data_r1_raw = 32'h1234_5678; #1;
    checks++; if (bus.id_data_r1 !== 32'h1234_5678) begin errors++; $display("FAIL reset_bypass got=%h exp=12345678", bus.id_data_r1); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  lts [5];
    logic [31:0] offs [5];
    logic [31:0] exps [5];
    lts[0] = 3'b000; offs[0] = 32'h1000_0001; exps[0] = 32'hFFFF_FF81;
    lts[1] = 3'b100; offs[1] = 32'h1000_0001; exps[1] = 32'h0000_0081;
    lts[2] = 3'b001; offs[2] = 32'h1000_0002; exps[2] = 32'hFFFF_F0F1;
    lts[3] = 3'b101; offs[3] = 32'h1000_0000; exps[3] = 32'h0000_8081;
    lts[4] = 3'b010; offs[4] = 32'h1000_0003; exps[4] = 32'h8081_F0F1;
    for (int i = 0; i < 5; i++) begin
      clock_in(1'b1, 1'b1, 1'b1, 5'd7, 2'b01, lts[i], offs[i], 32'h8081_F0F1, 32'h0);
      checks++;
      if (bus.rf_data_w !== exps[i] || bus.rf_we !== 1'b1) begin
        errors++;
        $display("FAIL load_ext[%0d] got data=%h we=%0b exp data=%h we=1", i, bus.rf_data_w, bus.rf_we, exps[i]);
      end
    end
  endtask

  task automatic test_link_zero();
    clock_in(1'b1, 1'b1, 1'b1, 5'd31, 2'b10, 3'b000, 32'hAAAA_0000, 32'h0, 32'h0040_0010);
    checks++;
    if (bus.rf_data_w !== 32'h0040_0010 || bus.rf_we !== 1'b1 || bus.rf_addr_w !== 5'd31) begin
      errors++;
      $display("FAIL link got data=%h we=%0b addr=%0d exp 00400010/1/31", bus.rf_data_w, bus.rf_we, bus.rf_addr_w);
    end
    clock_in(1'b1, 1'b1, 1'b1, 5'd0, 2'b10, 3'b000, 32'hAAAA_0000, 32'h0, 32'h0040_0010);
    bus.id_addr_r1 = 5'd0; bus.id_data_r1_raw = 32'h0; #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL link_r0_we got=%0b exp=0", bus.rf_we); end
    checks++; if (bus.id_data_r1 !== 32'h0) begin errors++; $display("FAIL r0_no_bypass got=%h exp=0", bus.id_data_r1); end
  endtask

  task automatic test_bypass();
    clock_in(1'b1, 1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0);
    bus.id_addr_r1 = 5'd5; bus.id_addr_r2 = 5'd5;
    bus.id_data_r1_raw = 32'h1111_1111; bus.id_data_r2_raw = 32'h1111_1111; #1;
    checks++; if (bus.id_data_r1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_r1 got=%h exp=deadbeef", bus.id_data_r1); end
    checks++; if (bus.id_data_r2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_r2 got=%h exp=deadbeef", bus.id_data_r2); end
    bus.id_addr_r1 = 5'd6; #1;
    checks++; if (bus.id_data_r1 !== 32'h1111_1111) begin errors++; $display("FAIL bypass_miss got=%h exp=11111111", bus.id_data_r1); end
  endtask

  task automatic test_stall();
    logic [31:0] c0;
    idle();
    idle();
    c0 = bus.retired_count;
    checks++; if (c0 !== m_cnt) begin errors++; $display("FAIL stall_start_count got=%h exp=%h", c0, m_cnt); end
    for (int i = 0; i < 3; i++) begin
      clock_in(1'b1, 1'b0, 1'b1, 5'd9, 2'b00, 3'b000, 32'h0000_0099, 32'h0, 32'h0);
      checks++;
      if (bus.rf_we !== 1'b0 || bus.wb_valid !== 1'b0) begin
        errors++; $display("FAIL stall_bubble[%0d] got we=%0b valid=%0b exp 0/0", i, bus.rf_we, bus.wb_valid);
      end
    end
    clock_in(1'b1, 1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'h0000_0099, 32'h0, 32'h0);
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_data_w !== 32'h0000_0099) begin
      errors++; $display("FAIL stall_write got we=%0b data=%h exp 1/00000099", bus.rf_we, bus.rf_data_w);
    end
    idle();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL stall_no_dup got=%0b exp=0", bus.rf_we); end
    checks++; if (bus.retired_count !== c0 + 32'd1) begin errors++; $display("FAIL stall_count got=%h exp=%h", bus.retired_count, c0 + 32'd1); end
  endtask

  task automatic test_random();
    logic        exp_we;
    logic [31:0] exp_r1;
    logic [31:0] exp_r2;
    for (int i = 0; i < 300; i++) begin
      clock_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
               5'($urandom_range(0, 7)), 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
      bus.id_addr_r1 = 5'($urandom_range(0, 7)); bus.id_addr_r2 = 5'($urandom_range(0, 7));
      bus.id_data_r1_raw = (bus.id_addr_r1 == 5'd0) ? 32'h0 : $urandom;
      bus.id_data_r2_raw = (bus.id_addr_r2 == 5'd0) ? 32'h0 : $urandom;
      #1;
      exp_we = m_we();
      exp_r1 = (exp_we && bus.id_addr_r1 == m_rd && bus.id_addr_r1 != 5'd0) ? m_res : bus.id_data_r1_raw;
      exp_r2 = (exp_we && bus.id_addr_r2 == m_rd && bus.id_addr_r2 != 5'd0) ? m_res : bus.id_data_r2_raw;
      checks++;
      if (bus.wb_valid !== m_valid || bus.rf_we !== exp_we || bus.retired_count !== m_cnt) begin
        errors++;
        $display("FAIL rand_ctrl[%0d] got valid=%0b we=%0b cnt=%h exp %0b/%0b/%h", i,
                 bus.wb_valid, bus.rf_we, bus.retired_count, m_valid, exp_we, m_cnt);
      end
      checks++;
      if (bus.rf_addr_w !== m_rd || bus.rf_data_w !== m_res) begin
        errors++;
        $display("FAIL rand_port[%0d] got addr=%0d data=%h exp %0d/%h", i, bus.rf_addr_w, bus.rf_data_w, m_rd, m_res);
      end
      checks++;
      if (bus.id_data_r1 !== exp_r1 || bus.id_data_r2 !== exp_r2) begin
        errors++;
        $display("FAIL rand_bypass[%0d] got r1=%h r2=%h exp %h/%h", i, bus.id_data_r1, bus.id_data_r2, exp_r1, exp_r2);
      end
    end
  endtask

  task automatic test_reset_midstream();
    clock_in(1'b1, 1'b1, 1'b1, 5'd12, 2'b00, 3'b000, 32'h5555_AAAA, 32'h0, 32'h0);
    clock_in(1'b1, 1'b1, 1'b1, 5'd13, 2'b00, 3'b000, 32'h6666_BBBB, 32'h0, 32'h0);
    checks++;
    if (bus.rf_we !== 1'b1 || bus.wb_valid !== 1'b1 || bus.retired_count === 32'h0) begin
      errors++; $display("FAIL midrst_pre got we=%0b valid=%0b cnt=%h exp 1/1/nonzero", bus.rf_we, bus.wb_valid, bus.retired_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL midrst_we got=%0b exp=0", bus.rf_we); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b exp=0", bus.wb_valid); end
    checks++; if (bus.retired_count !== 32'h0) begin errors++; $display("FAIL midrst_count got=%h exp=0", bus.retired_count); end
    checks++; if (bus.rf_data_w !== 32'h0 || bus.rf_addr_w !== 5'd0) begin errors++; $display("FAIL midrst_port got addr=%0d data=%h exp 0/0", bus.rf_addr_w, bus.rf_data_w); end
    model_reset();
    bus.mem_valid = 1'b0;
    #1 rst = 1'b0;
    clock_in(1'b1, 1'b1, 1'b1, 5'd14, 2'b00, 3'b000, 32'h0000_0E0E, 32'h0, 32'h0);
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_data_w !== 32'h0000_0E0E || bus.retired_count !== 32'h0) begin
      errors++; $display("FAIL post_rst_capture got we=%0b data=%h cnt=%h exp 1/00000e0e/0", bus.rf_we, bus.rf_data_w, bus.retired_count);
    end
  endtask

  task automatic test_wrap();
    idle();
    idle();
    force dut.retired_count_q = 32'hFFFF_FFFE;
    #1 release dut.retired_count_q;
    m_cnt = 32'hFFFF_FFFE;
    clock_in(1'b1, 1'b1, 1'b0, 5'd3, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0);
    clock_in(1'b1, 1'b1, 1'b0, 5'd3, 2'b00, 3'b000, 32'h2, 32'h0, 32'h0);
    checks++; if (bus.retired_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pre got=%h exp=ffffffff", bus.retired_count); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL nowrite_instr got=%0b exp=0", bus.rf_we); end
    idle();
    checks++; if (bus.retired_count !== 32'h0) begin errors++; $display("FAIL wrap got=%h exp=0", bus.retired_count); end
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    bus.mem_valid = 1'b0; bus.mem_ready = 1'b1; bus.mem_reg_write = 1'b0; bus.mem_rd = 5'd0;
    bus.mem_wb_sel = 2'b00; bus.mem_load_type = 3'b000; bus.mem_alu_result = 32'h0;
    bus.mem_load_data = 32'h0; bus.mem_pc_plus8 = 32'h0;
    bus.id_addr_r1 = 5'd0; bus.id_addr_r2 = 5'd0;
    bus.id_data_r1_raw = 32'h0; bus.id_data_r2_raw = 32'h0;
    #12;
    test_reset();
    #1 rst = 1'b0;
    test_load_ext();
    test_link_zero();
    test_bypass();
    test_stall();
    test_random();
    test_reset_midstream();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
